// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   feeding the 7-segment digit decoders. The digits/blank outputs are
//   registered and only change when a conversion completes, so the display
//   never shows intermediate values.
//
// Parameters:
//   WIDTH   binary input width (>= 2)
//   DIGITS  number of BCD digits; 10**DIGITS must exceed 2**WIDTH - 1
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   conversion request, accepted only while ready = 1
//   bin     unsigned input, sampled on the accepting edge only
//   ready   idle and able to accept start
//   valid   one-cycle pulse: digits/blank just updated
//   digits  BCD result, digit i at [4i+3:4i], digit 0 = units
//   blank   blank[i] = 1 -> display digit i dark
//
// Build option:
//   BIN2BCD_LZB_EN  when defined, blank carries a registered leading-zero
//                   mask (blank[0] always 0); otherwise blank is tied low.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  ready,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     blank
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;
   localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;

   // True when DIGITS decimal digits can represent every WIDTH-bit value.
   function automatic logic digits_fit();
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (p > MAXV) return 1'b1;
         p = p * 64'd10;
      end
      return (p > MAXV);
   endfunction

   if (!digits_fit()) begin : g_param_check
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
   end

   logic             state;
   logic [WIDTH-1:0] sreg;
   logic [BW-1:0]    work;
   logic [CW-1:0]    cnt;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    work_nxt;
   logic [WIDTH-1:0] sreg_nxt;

   // One double-dabble step: nibble-wise add-3 (no inter-nibble carry), then
   // shift {work, sreg} left with the binary MSB entering work bit 0.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      adj = work;
      for (int i = 0; i < DIGITS; i++) begin
         if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
      work_nxt = {adj[BW-2:0], sreg[WIDTH-1]};
      sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
   end

   assign ready = (state == IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sreg   <= '0;
         work   <= '0;
         cnt    <= '0;
         digits <= '0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               sreg  <= bin;
               work  <= '0;
               cnt   <= CW'(WIDTH);
               state <= SHIFT;
            end
         end else begin
            sreg <= sreg_nxt;
            work <= work_nxt;
            cnt  <= cnt - CW'(1);
            // Last bit: publish the finished value alongside the valid pulse.
            if (cnt == CW'(1)) begin
               digits <= work_nxt;
               valid  <= 1'b1;
               state  <= IDLE;
            end
         end
      end
   end

`ifdef BIN2BCD_LZB_EN
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   logic [DIGITS-1:0] blank_nxt;
   logic              any_nz;

   // Scan from the most significant digit down; a digit is dark while it and
   // every digit above it are zero. Digit 0 is never blanked.
   always_comb begin
      blank_nxt = '0;
      any_nz    = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         any_nz       = any_nz | (work_nxt[4*i +: 4] != 4'd0);
         blank_nxt[i] = ~any_nz;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blank <= BLANK_RST;
      end else if (state == SHIFT && cnt == CW'(1)) begin
         blank <= blank_nxt;
      end
   end
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq (WIDTH = 8, DIGITS = 3). Expected
//   digits come from decimal division of the input; expected blanking from
//   comparing the input against powers of ten. Define BIN2BCD_LZB_EN for
//   both bench and RTL to exercise the blanking build.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

   localparam int W = 8;
   localparam int D = 3;

`ifdef BIN2BCD_LZB_EN
   localparam logic [D-1:0] RST_BLANK = 3'b110;
`else
   localparam logic [D-1:0] RST_BLANK = 3'b000;
`endif

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  bin;
   logic          ready;
   logic          valid;
   logic [4*D-1:0] digits;
   logic [D-1:0]  blank;

   int n_checks = 0;
   int n_pass   = 0;

   logic [4*D-1:0] last_d;
   logic [D-1:0]   last_b;

   bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin    (bin),
      .ready  (ready),
      .valid  (valid),
      .digits (digits),
      .blank  (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits by division.
   function automatic logic [4*D-1:0] ref_digits(input int v);
      logic [4*D-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Reference: digit i (i >= 1) is dark when the value is below 10**i.
   function automatic logic [D-1:0] ref_blank(input int v);
      logic [D-1:0] b;
      int p;
      b = '0;
`ifdef BIN2BCD_LZB_EN
      p = 10;
      for (int i = 1; i < D; i++) begin
         b[i] = (v < p);
         p = p * 10;
      end
`else
      p = v;
`endif
      return b;
   endfunction

   function automatic logic [2+4*D+D-1:0] obs();
      return {ready, valid, digits, blank};
   endfunction

   // One conversion of v. prestarted: start was already accepted in the
   // preceding valid cycle. inj_cycle/inj_val: start pulse raised while busy.
   // chain: raise start with chain_val in this conversion's valid cycle.
   task automatic run_conv(input string tag, input int v, input bit prestarted,
                           input int inj_cycle, input int inj_val,
                           input bit chain, input int chain_val);
      logic [2+4*D+D-1:0] exp_v;
      logic [2+4*D+D-1:0] got;
      if (!prestarted) begin
         @(posedge clk); #1;
         start = 1'b1;
         bin   = W'(v);
         @(negedge clk);
         exp_v = {1'b1, 1'b0, last_d, last_b};
         got   = obs();
         n_checks++;
         if (got !== exp_v)
            $display("FAIL %s c0: got r/v/d/b=%h want %h", tag, got, exp_v);
         else n_pass++;
      end
      for (int c = 1; c <= W + 1; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         bin   = W'($urandom);
         if (c == inj_cycle) begin start = 1'b1; bin = W'(inj_val); end
         if (c == W + 1 && chain) begin start = 1'b1; bin = W'(chain_val); end
         @(negedge clk);
         if (c <= W) exp_v = {1'b0, 1'b0, last_d, last_b};
         else        exp_v = {1'b1, 1'b1, ref_digits(v), ref_blank(v)};
         got = obs();
         n_checks++;
         if (got !== exp_v)
            $display("FAIL %s v=%0d c%0d: got r/v/d/b=%h want %h", tag, v, c, got, exp_v);
         else n_pass++;
      end
      last_d = ref_digits(v);
      last_b = ref_blank(v);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs() !== {1'b1, 1'b0, 12'h000, RST_BLANK})
         $display("FAIL reset: got r/v/d/b=%h want %h", obs(), {1'b1, 1'b0, 12'h000, RST_BLANK});
      else n_pass++;
      rst_n  = 1'b1;
      last_d = '0;
      last_b = RST_BLANK;
   endtask

   task automatic test_full_scale();
      run_conv("full_scale", 255, 1'b0, 0, 0, 1'b0, 0);
      n_checks++;
      if ({digits, blank} !== {12'h255, 3'b000})
         $display("FAIL full_scale_value: got %h/%b want 255/000", digits, blank);
      else n_pass++;
   endtask

   task automatic test_leading_zeros();
      run_conv("lz_7",   7,   1'b0, 0, 0, 1'b0, 0);
      run_conv("lz_100", 100, 1'b0, 0, 0, 1'b0, 0);
      run_conv("lz_0",   0,   1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_busy();
      run_conv("busy", 42, 1'b0, 4, 99, 1'b0, 0);
      // The ignored request must not produce a second result.
      for (int c = 0; c < W + 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({ready, valid, digits} !== {1'b1, 1'b0, 12'h042})
            $display("FAIL busy_after c%0d: got r/v/d=%b/%b/%h want 1/0/042", c, ready, valid, digits);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      run_conv("b2b_a", 19,  1'b0, 0, 0, 1'b1, 200);
      run_conv("b2b_b", 200, 1'b1, 0, 0, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      start = 1'b1;
      bin   = 8'd128;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;                       // cycle 5
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs() !== {1'b1, 1'b0, 12'h000, RST_BLANK})
         $display("FAIL reset_mid: got r/v/d/b=%h want %h", obs(), {1'b1, 1'b0, 12'h000, RST_BLANK});
      else n_pass++;
      for (int c = 0; c < W + 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({ready, valid} !== 2'b10)
            $display("FAIL reset_mid_quiet c%0d: got r/v=%b/%b want 1/0", c, ready, valid);
         else n_pass++;
      end
      last_d = '0;
      last_b = RST_BLANK;
      run_conv("after_reset", 64, 1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_random();
      int v;
      int nv;
      bit pre;
      pre = 1'b0;
      v   = int'($urandom_range(0, 255));
      for (int k = 0; k < 24; k++) begin
         nv = int'($urandom_range(0, 255));
         // Alternate between chained and isolated conversions.
         run_conv("random", v, pre, int'($urandom_range(1, W)), int'($urandom_range(0, 255)),
                  k[0], nv);
         pre = k[0];
         v   = nv;
      end
      if (pre) run_conv("random_tail", v, 1'b1, 0, 0, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_leading_zeros();
      test_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
